m_div_unit: RTL

Parametrised, self-sequencing integer divider for the M-extension execute stage. It implements RISC-V DIV, DIVU, REM and REMU with a restoring shift-subtract algorithm on internal remainder (R), divisor (D) and quotient (Z) registers. Its own FSM and start/done handshake replace external mux sequencing. Width and radix (quotient bits per cycle) are parameters, and the RISC-V divide-by-zero and signed-overflow cases take a 1-cycle early-out path.

---
 rtl/m_div_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/m_div_unit.sv
// Self-sequencing restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Retires BITS_PER_CYCLE quotient bits per CALC cycle; div-by-zero and signed overflow short-circuit through FIX.
`timescale 1ns/1ps
module m_div_unit #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned NSTEP = XLEN / BITS_PER_CYCLE;
   localparam int unsigned CW    = $clog2(NSTEP + 1);
   localparam int unsigned DW    = 2 * XLEN - 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] r_q, r_d;
   logic [DW-1:0]   d_q, d_d;
   logic [XLEN-1:0] z_q, z_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic            s1_q, s1_d;
   logic            s2_q, s2_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            accept, sgn, s1_in, s2_in, div0, ovf;
   logic [XLEN-1:0] abs1, abs2, quo, rem;
   logic [XLEN-1:0] r_t, z_t;
   logic [DW-1:0]   d_t;

   // Operand conditioning at accept and sign fix-up of the final Z/R
   always_comb begin
      accept = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
      sgn    = !op[0];
      s1_in  = rs1[XLEN-1] & sgn;
      s2_in  = rs2[XLEN-1] & sgn;
      abs1   = s1_in ? XLEN'(-rs1) : rs1;
      abs2   = s2_in ? XLEN'(-rs2) : rs2;
      div0   = (rs2 == '0);
      ovf    = sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
      quo    = (s1_q ^ s2_q) ? XLEN'(-z_q) : z_q;
      rem    = s1_q ? XLEN'(-r_q) : r_q;
   end

   // Next-state and datapath
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      d_d      = d_q;
      z_d      = z_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;
      r_t      = r_q;
      d_t      = d_q;
      z_t      = z_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (accept) begin
               op_d = op;
               // Early-outs preload Z/R with the final answer and skip CALC
               if (div0) begin
                  z_d     = '1;
                  r_d     = rs1;
                  s1_d    = 1'b0;
                  s2_d    = 1'b0;
                  state_d = S_FIX;
               end else if (ovf) begin
                  z_d     = rs1;
                  r_d     = '0;
                  s1_d    = 1'b0;
                  s2_d    = 1'b0;
                  state_d = S_FIX;
               end else begin
                  s1_d    = s1_in;
                  s2_d    = s2_in;
                  r_d     = abs1;
                  d_d     = DW'(abs2) << (XLEN - 1);
                  z_d     = '0;
                  cnt_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
               // R >= D is the non-negative-difference test; D < 2^XLEN whenever it holds
               if ({{(XLEN-1){1'b0}}, r_t} >= d_t) begin
                  r_t = r_t - d_t[XLEN-1:0];
                  z_t = {z_t[XLEN-2:0], 1'b1};
               end else begin
                  z_t = {z_t[XLEN-2:0], 1'b0};
               end
               d_t = d_t >> 1;
            end
            r_d   = r_t;
            d_d   = d_t;
            z_d   = z_t;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NSTEP - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = op_q[1] ? rem : quo;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end

      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         r_q      <= '0;
         d_q      <= '0;
         z_q      <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         d_q      <= d_d;
         z_q      <= z_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
